// File: rtl/platform_field.sv
// platform_field: keeps N_PLAT platform positions for the playfield. On start it
// lays out a fresh set. On each accepted frame tick it applies scroll and drift,
// bounces moving platforms between the edges, and respawns platforms that leave
// the bottom of the screen.
module platform_field #(
  parameter int unsigned N_PLAT = 8,
  parameter int unsigned H      = 240,
  parameter int unsigned X_MIN  = 70,
  parameter int unsigned X_MAX  = 249,
  parameter int unsigned PLAT_W = 60,
  parameter int unsigned DRIFT  = 1,
  parameter int unsigned SPEED  = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  frame_clk_edge,
  input  logic        start,
  input  logic [15:0] seed,
  input  logic [9:0]  scroll,
  output logic [9:0]  Platform_X_out  [0:N_PLAT-1],
  output logic [9:0]  Platform_Y_out  [0:N_PLAT-1],
  output logic        Platform_moving [0:N_PLAT-1],
  output logic        busy,
  output logic        frame_done,
  output logic        overrun,
  output logic [15:0] respawn_count
);

  localparam int unsigned XR    = X_MAX - PLAT_W;
  localparam int unsigned SPAN  = XR - X_MIN + 1;
  localparam int unsigned YSTEP = H / N_PLAT;
  localparam int unsigned IW    = (N_PLAT > 1) ? $clog2(N_PLAT) : 1;
  localparam logic [15:0] SEED_DFLT = 16'hACE1;

  typedef enum logic [1:0] {IDLE, INIT, RUN, UPDATE} state_t;

  state_t        state_q, state_nxt;
  logic [IW-1:0] idx_q;
  logic [9:0]    scroll_q;
  logic [15:0]   lfsr_q;
  logic          dir_q [0:N_PLAT-1];

  logic          tick_c, last_c, active_c;
  logic [15:0]   lfsr_nxt_c;
  logic [7:0]    off_c;
  logic [9:0]    spawn_x_c, init_y_c;
  logic          spawn_mv_c, spawn_dir_c;
  logic [9:0]    cur_x_c, cur_y_c;
  logic          cur_mv_c, cur_dir_c;
  logic [10:0]   ynew_c, ywrap_c;
  logic          respawn_c;
  logic [9:0]    upd_x_c, upd_y_c;
  logic          upd_dir_c;

  assign tick_c   = (frame_clk_edge == 2'b01);
  assign last_c   = (idx_q == IW'(N_PLAT - 1));
  assign active_c = (state_q == INIT) || (state_q == UPDATE);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // Next-state logic; start overrides everything, including a simultaneous tick
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    state_nxt = IDLE;
      INIT:    if (last_c) state_nxt = RUN;
      RUN:     if (tick_c) state_nxt = UPDATE;
      UPDATE:  if (last_c) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = INIT;
  end

  // Per-platform datapath: spawn values from the stepped LFSR, plus move/respawn math
  always_comb begin
    lfsr_nxt_c  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    off_c       = {1'b0, lfsr_nxt_c[6:0]};
    if (off_c >= 8'(SPAN)) off_c = off_c - 8'(SPAN);
    spawn_x_c   = 10'(X_MIN) + 10'(off_c);
    spawn_mv_c  = (lfsr_nxt_c[9:8] == 2'b11);
    spawn_dir_c = lfsr_nxt_c[10];
    init_y_c    = 10'(32'(idx_q) * YSTEP);

    cur_x_c   = Platform_X_out[idx_q];
    cur_y_c   = Platform_Y_out[idx_q];
    cur_mv_c  = Platform_moving[idx_q];
    cur_dir_c = dir_q[idx_q];

    ynew_c    = 11'(cur_y_c) + 11'(DRIFT) + 11'(scroll_q);
    ywrap_c   = ynew_c - 11'(H);
    respawn_c = (ynew_c > 11'(H - 1));
    upd_y_c   = ynew_c[9:0];
    if (respawn_c) upd_y_c = (ywrap_c > 11'(H - 1)) ? 10'd0 : ywrap_c[9:0];

    upd_x_c   = cur_x_c;
    upd_dir_c = cur_dir_c;
    if (respawn_c) begin
      upd_x_c   = spawn_x_c;
      upd_dir_c = spawn_dir_c;
    end else if (cur_mv_c) begin
      if (cur_dir_c) begin
        if (11'(cur_x_c) + 11'(SPEED) > 11'(XR)) begin
          upd_x_c   = 10'(XR);
          upd_dir_c = 1'b0;
        end else begin
          upd_x_c = cur_x_c + 10'(SPEED);
        end
      end else begin
        if (11'(cur_x_c) < 11'(X_MIN + SPEED)) begin
          upd_x_c   = 10'(X_MIN);
          upd_dir_c = 1'b1;
        end else begin
          upd_x_c = cur_x_c - 10'(SPEED);
        end
      end
    end
  end

  // Platform table, LFSR, index and status outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < int'(N_PLAT); i++) begin
        Platform_X_out[i]  <= '0;
        Platform_Y_out[i]  <= '0;
        Platform_moving[i] <= 1'b0;
        dir_q[i]           <= 1'b1;
      end
      lfsr_q        <= (seed == 16'h0000) ? SEED_DFLT : seed;
      idx_q         <= '0;
      scroll_q      <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      overrun       <= 1'b0;
      respawn_count <= '0;
    end else begin
      busy       <= (state_nxt == INIT) || (state_nxt == UPDATE);
      frame_done <= active_c && last_c && !start;
      overrun    <= active_c && tick_c && !start;
      if (start) begin
        idx_q         <= '0;
        respawn_count <= '0;
      end else begin
        case (state_q)
          INIT: begin
            Platform_X_out[idx_q]  <= spawn_x_c;
            Platform_Y_out[idx_q]  <= init_y_c;
            Platform_moving[idx_q] <= spawn_mv_c;
            dir_q[idx_q]           <= spawn_dir_c;
            lfsr_q                 <= lfsr_nxt_c;
            idx_q                  <= last_c ? '0 : idx_q + IW'(1);
          end
          RUN: begin
            if (tick_c) begin
              scroll_q <= scroll;
              idx_q    <= '0;
            end
          end
          UPDATE: begin
            Platform_X_out[idx_q] <= upd_x_c;
            Platform_Y_out[idx_q] <= upd_y_c;
            dir_q[idx_q]          <= upd_dir_c;
            if (respawn_c) begin
              Platform_moving[idx_q] <= spawn_mv_c;
              lfsr_q                 <= lfsr_nxt_c;
              if (respawn_count != 16'hFFFF) respawn_count <= respawn_count + 16'd1;
            end
            idx_q <= last_c ? '0 : idx_q + IW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/platform_field.md
# platform_field

Parametrised successor to the fixed eight-platform mover: maintains N_PLAT platforms for the Doodle Jump playfield, places them on start, and updates them on each frame tick. Each update applies camera scroll plus base drift, bounces moving platforms between the playfield edges, and respawns platforms that fall off the bottom at a pseudo-random X taken from an internal LFSR. Platform positions feed the sprite renderer and collision logic. The block sits between the game FSM (which drives start and scroll) and the draw/collision path.

## Interface
Parameters:
- N_PLAT, 8, number of platforms (2..16)
- H, 240, screen height in pixels
- X_MIN, 70, leftmost playfield X
- X_MAX, 249, rightmost playfield X
- PLAT_W, 60, platform width; right bound XR = X_MAX-PLAT_W (default 189)
- DRIFT, 1, pixels per frame added to every Y
- SPEED, 1, pixels per frame a moving platform travels in X

Ports:
- Clk  in  1  50 MHz system clock; all state changes on its rising edge.
- Reset  in  1  reset, synchronous and active-high.
- frame_clk_edge  in  2  a value of 2'b01 is a frame tick.
- start  in  1  one-cycle pulse that (re)loads the initial layout.
- seed  in  16  LFSR seed, sampled while Reset is high.
- scroll  in  10  camera scroll for this frame in pixels, sampled on the accepted tick.
- Platform_X_out [0:N_PLAT-1]  out  10  platform left X.
- Platform_Y_out [0:N_PLAT-1]  out  10  platform top Y.
- Platform_moving [0:N_PLAT-1]  out  1  platform moves horizontally.
- busy  out  1  high while the block is in INIT or UPDATE.
- frame_done  out  1  one-cycle pulse when INIT or UPDATE completes.
- overrun  out  1  one-cycle pulse when a tick arrives while busy.
- respawn_count  out  16  number of respawns since the last start; saturates at 16'hFFFF.

## Operation
- State machine: IDLE -> INIT -> RUN -> UPDATE -> RUN.
  - start is honoured in every state except while Reset is high. It forces INIT with index 0 and clears respawn_count.
  - start wins over a simultaneous tick.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Loaded with seed on Reset; seed 0 loads 16'hACE1.
  - Steps once per platform written in INIT and once per respawn, never otherwise.
- Spawn X uses SPAN = XR-X_MIN+1 (default 120; 64 ≤ SPAN ≤ 128 is required).
  - off = lfsr[6:0]; if off ≥ SPAN then off -= SPAN.
  - X = X_MIN+off.
- Spawn moving = (lfsr[9:8]==2'b11). Spawn direction: right if lfsr[10]=1.
- INIT: one platform per cycle, index i = 0..N_PLAT-1.
  - Y[i] = i*(H/N_PLAT).
  - X, moving and dir come from the LFSR.
- UPDATE: on a tick in RUN, latch scroll, then process one platform per cycle, i = 0..N_PLAT-1.
  - Y arithmetic uses 11 bits: Ynew = Y+DRIFT+scroll.
  - If Ynew > H-1: respawn. Y = Ynew-H (if still > H-1, Y = 0); new X, moving and dir from the LFSR; respawn_count increments.
  - Otherwise, if moving: step X by SPEED in dir.
    - If the step would pass XR: X = XR and dir flips to left.
    - If the step would pass X_MIN: X = X_MIN and dir flips to right.
  - A non-moving platform keeps its X.
- A tick during INIT or UPDATE is ignored and pulses overrun. Ticks in IDLE are ignored silently.

## Timing
- Reset values: every X/Y = 0, moving = 0, dir = right, busy = 0, frame_done = 0, overrun = 0, respawn_count = 0, state IDLE.
- start in cycle t: busy rises at t+1; platform i is written at the edge ending cycle t+1+i.
- INIT and UPDATE each take N_PLAT cycles. frame_done pulses in the cycle after the last write, and busy falls in that same cycle.
- Tick in RUN at cycle t: same schedule as start.
- Outputs are registered. Index i changes only in its own cycle, so the renderer may see a mix of old and new values during UPDATE.
- Reset mid-INIT or mid-UPDATE: reset values apply on the next edge; the partial frame is discarded.
- overrun pulses in the cycle after the offending tick.

## Test plan
- Reset with seed 0 -> all outputs 0, IDLE. Then start -> busy for exactly 8 cycles; Y = 0, 30, ..., 210; every X in [70,189]; frame_done pulses once.
- Reset with seed 16'h0001, then start -> platform 0 X equals the first LFSR step mapped through SPAN. The sequence is identical across two runs with the same seed.
- In RUN, tick with scroll = 0 -> each Y increases by 1 after 8 cycles, frame_done pulses, X of non-moving platforms is unchanged.
- Platform at Y = 230, tick with scroll = 15 -> Y = 6, new X in [70,189], respawn_count = 1.
- Moving platform at X = 188, dir right -> ticks give 189 (right), 189 (dir flips), 188. At X = 71, dir left -> 70, then flips to right.
- Tick at the 3rd UPDATE cycle -> overrun pulses and the frame still ends after 8 cycles. start concurrent with a tick -> INIT. Reset mid-UPDATE -> all zeros next cycle.
